// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the pipelined radix-4 Booth multiplier.
//   - booth_t     : Booth digit codes (zero, +1, +2, -1, -2)
//   - booth_enc   : maps a 3-bit multiplier window to a Booth digit
//   - npp         : number of partial products for a given operand width
//   - rows_after  : row count left after a number of 4:2 compressor levels
//   - tree_levels : number of 4:2 levels needed to reach two rows
//   - S1_TREE_LEVELS : compressor levels placed in the first stage
package mul_pkg;

  typedef enum logic [2:0] {
    BOOTH_ZERO = 3'd0,
    BOOTH_P1   = 3'd1,
    BOOTH_P2   = 3'd2,
    BOOTH_M1   = 3'd3,
    BOOTH_M2   = 3'd4
  } booth_t;

  // The first stage also does the Booth encode, so it gets one level only;
  // the second stage takes every level that remains.
  localparam int S1_TREE_LEVELS = 1;

  function automatic int npp(input int width);
    return (width + 2) / 2;
  endfunction

  // Each level pads its rows to a multiple of four and halves them.
  function automatic int rows_after(input int n_rows, input int levels);
    int n;
    n = n_rows;
    for (int i = 0; i < levels; i++) begin
      n = 2 * ((n + 3) / 4);
    end
    return n;
  endfunction

  function automatic int tree_levels(input int n_rows);
    int n;
    int c;
    n = n_rows;
    c = 0;
    while (n > 2) begin
      n = 2 * ((n + 3) / 4);
      c++;
    end
    return c;
  endfunction

  // Window is {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_t booth_enc(input logic [2:0] win);
    booth_t d;
    case (win)
      3'b001, 3'b010: d = BOOTH_P1;
      3'b011:         d = BOOTH_P2;
      3'b100:         d = BOOTH_M2;
      3'b101, 3'b110: d = BOOTH_M1;
      default:        d = BOOTH_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/csa42_row.sv
// csa42_row: one row of W 4:2 compressors (combinational).
// Ports:
//   a, b, c, d : four W-bit addend rows
//   sum        : W-bit sum row
//   carry      : W-bit carry row, already shifted left by one
// Guarantees a+b+c+d == sum+carry modulo 2^W.
module csa42_row #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  logic [W-1:0] s1;
  logic [W-2:0] co;
  logic [W-1:0] cin;
  logic [W-2:0] cy;

  // First full adder per column; its carry feeds the next column's second
  // adder. It depends only on a/b/c, so the chain never ripples.
  assign s1  = a ^ b ^ c;
  assign co  = (a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]);
  assign cin = {co, 1'b0};

  assign sum = s1 ^ d ^ cin;
  assign cy  = (s1[W-2:0] & d[W-2:0]) | (s1[W-2:0] & cin[W-2:0]) | (d[W-2:0] & cin[W-2:0]);
  assign carry = {cy, 1'b0};

endmodule

// File: rtl/pipe_booth_mul.sv
// pipe_booth_mul: three-stage radix-4 Booth multiplier with valid/ready.
//   S1: extend operands by 2 bits, Booth encode, first 4:2 level
//   S2: remaining 4:2 levels down to two rows
//   S3: carry-propagate add into out_p
// Ports:
//   clk, reset (sync, active-high), flush (drops all in-flight work)
//   in_valid/in_ready, in_signed, in_a, in_b : operand handshake
//   out_valid/out_ready, out_p               : product handshake
// Build option MUL_ACC_EN adds in_acc, in_acc_en, in_acc_sub and yields
// out_p = in_acc +/- a*b (mod 2^(2*WIDTH)) with the same latency.
module pipe_booth_mul
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
`ifdef MUL_ACC_EN
  input  logic [2*WIDTH-1:0]   in_acc,
  input  logic                 in_acc_en,
  input  logic                 in_acc_sub,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p
);

  localparam int PW  = 2 * WIDTH;
  localparam int EW  = WIDTH + 2;
  localparam int NPP = npp(WIDTH);
`ifdef MUL_ACC_EN
  localparam int NACC = 1;
`else
  localparam int NACC = 0;
`endif
  // Booth rows, one negate-correction row, optional accumulator row.
  localparam int N0  = NPP + 1 + NACC;
  localparam int NG1 = (N0 + 3) / 4;
  localparam int N1  = rows_after(N0, S1_TREE_LEVELS);
  localparam int NL2 = tree_levels(N1);

  // ---------------------------------------------------------------- control
  logic v1, v2;
  logic adv1, adv2, adv3;

  assign adv3     = !out_valid || out_ready;
  assign adv2     = !v2 || adv3;
  assign adv1     = !v1 || adv2;
  assign in_ready = adv1;

  // ---------------------------------------------------------- S1: encoding
  logic [EW-1:0] a_ext, b_ext;
  logic [PW-1:0] a_sx;
  logic [EW:0]   b_win;
  logic          sub;
  logic [PW-1:0] pp [4*NG1];

  assign a_ext = {{2{in_signed & in_a[WIDTH-1]}}, in_a};
  assign b_ext = {{2{in_signed & in_b[WIDTH-1]}}, in_b};
  assign a_sx  = {{(PW-EW){a_ext[EW-1]}}, a_ext};
  assign b_win = {b_ext, 1'b0};

`ifdef MUL_ACC_EN
  assign sub = in_acc_en & in_acc_sub;
`else
  assign sub = 1'b0;
`endif

  // Each partial product is fully sign-extended to PW bits. Negation is
  // done as ~mag before the shift, so the +1 lands at bit 2i and all of
  // them fit into one correction row. Subtract flips every digit's sign,
  // which negates the whole product through the same path.
  always_comb begin
    booth_t        dig;
    logic [PW-1:0] mag;
    logic          neg;
    dig = BOOTH_ZERO;
    mag = '0;
    neg = 1'b0;
    for (int k = 0; k < 4*NG1; k++) begin
      pp[k] = '0;
    end
    for (int i = 0; i < NPP; i++) begin
      dig = booth_enc(b_win[2*i +: 3]);
      case (dig)
        BOOTH_P1, BOOTH_M1: mag = a_sx;
        BOOTH_P2, BOOTH_M2: mag = a_sx << 1;
        default:            mag = '0;
      endcase
      neg = ((dig == BOOTH_M1) || (dig == BOOTH_M2)) ^ sub;
      pp[i] = (neg ? ~mag : mag) << (2*i);
      pp[NPP][2*i] = neg;
    end
`ifdef MUL_ACC_EN
    pp[NPP+1] = in_acc_en ? in_acc : '0;
`endif
  end

  logic [PW-1:0] l1_rows [N1];

  for (genvar g = 0; g < NG1; g++) begin : g_l1
    csa42_row #(.W(PW)) u_row (
      .a     (pp[4*g]),
      .b     (pp[4*g+1]),
      .c     (pp[4*g+2]),
      .d     (pp[4*g+3]),
      .sum   (l1_rows[2*g]),
      .carry (l1_rows[2*g+1])
    );
  end

  logic [PW-1:0] s1_rows [N1];

  // ------------------------------------------------------ S2: tree levels
  // lv[l] holds the rows entering S2 level l; unused slots are tied to zero.
  logic [PW-1:0] lv [NL2+1][N1];

  for (genvar k = 0; k < N1; k++) begin : g_lv0
    assign lv[0][k] = s1_rows[k];
  end

  for (genvar l = 0; l < NL2; l++) begin : g_l2
    localparam int NI = rows_after(N1, l);
    localparam int NG = (NI + 3) / 4;
    logic [PW-1:0] rin [4*NG];

    for (genvar k = 0; k < 4*NG; k++) begin : g_in
      if (k < NI) begin : g_row
        assign rin[k] = lv[l][k];
      end else begin : g_pad
        assign rin[k] = '0;
      end
    end

    for (genvar g = 0; g < NG; g++) begin : g_csa
      csa42_row #(.W(PW)) u_row (
        .a     (rin[4*g]),
        .b     (rin[4*g+1]),
        .c     (rin[4*g+2]),
        .d     (rin[4*g+3]),
        .sum   (lv[l+1][2*g]),
        .carry (lv[l+1][2*g+1])
      );
    end

    for (genvar k = 2*NG; k < N1; k++) begin : g_zero
      assign lv[l+1][k] = '0;
    end
  end

  logic [PW-1:0] s2_sum, s2_carry;

  // --------------------------------------------------------------- registers
  // Data registers only load when carrying a valid operation; their contents
  // are don't-care otherwise.
  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      for (int k = 0; k < N1; k++) begin
        s1_rows[k] <= l1_rows[k];
      end
    end
    if (adv2 && v1) begin
      s2_sum   <= lv[NL2][0];
      s2_carry <= lv[NL2][1];
    end
  end

  // S3 final adder; carry-out beyond PW bits is dropped. flush keeps out_p.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      out_p     <= '0;
    end else if (flush) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (adv1) v1 <= in_valid;
      if (adv2) v2 <= v1;
      if (adv3) begin
        out_valid <= v2;
        if (v2) out_p <= s2_sum + s2_carry;
      end
    end
  end

endmodule

// File: tb/tb_pipe_booth_mul.sv
// tb_pipe_booth_mul: directed bench for pipe_booth_mul at WIDTH=32.
// Covers reset state, latency, signed/unsigned corner products, stall with
// back-pressure, flush, mid-stream reset, a short streamed sweep against a
// behavioural model, and the accumulate build when MUL_ACC_EN is defined.
module tb_pipe_booth_mul;

  localparam int W = 32;
  localparam int N_RAND = 2000;

  logic            clk = 1'b0;
  logic            reset, flush;
  logic            in_valid, in_ready, in_signed;
  logic [W-1:0]    in_a, in_b;
  logic            out_valid, out_ready;
  logic [2*W-1:0]  out_p;
`ifdef MUL_ACC_EN
  logic [2*W-1:0]  in_acc;
  logic            in_acc_en, in_acc_sub;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_booth_mul #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_signed  (in_signed),
    .in_a       (in_a),
    .in_b       (in_b),
`ifdef MUL_ACC_EN
    .in_acc     (in_acc),
    .in_acc_en  (in_acc_en),
    .in_acc_sub (in_acc_sub),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_p      (out_p)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    logic signed [63:0] sa, sb;
    if (sgn) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end else begin
      sa = {32'b0, a};
      sb = {32'b0, b};
    end
    return sa * sb;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'h0000_0000;
      1:       v = 32'h0000_0001;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h8000_0000;
      4:       v = 32'h7FFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // One isolated operation: checks acceptance, 3-cycle latency and drain.
  task automatic single_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input logic [63:0] exp);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_signed = sgn;
    check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    tick;
    in_valid = 1'b0;
    check({tag, "_c1"}, 64'(out_valid), 64'd0);
    tick;
    check({tag, "_c2"}, 64'(out_valid), 64'd0);
    tick;
    check({tag, "_c3v"}, 64'(out_valid), 64'd1);
    check({tag, "_p"}, out_p, exp);
    tick;
    check({tag, "_c4"}, 64'(out_valid), 64'd0);
  endtask

  logic [31:0] st_a [5];
  logic [31:0] st_b [5];
  logic        st_s [5];
  logic [63:0] st_e [5];
  logic [63:0] q [$];

  initial begin
    int   issued, recv, first_cyc, n_sent, n_recv;
    logic exp_rdy;
    bit   accepted;

    reset = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_signed = 1'b0; in_a = '0; in_b = '0;
    out_ready = 1'b1;
`ifdef MUL_ACC_EN
    in_acc = '0; in_acc_en = 1'b0; in_acc_sub = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_p", out_p, 64'd0);
    check("rst_rdy", 64'(in_ready), 64'd1);
    tick;

    // corner products
    single_op("s_m1m1",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
    single_op("u_m1m1",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    single_op("s_minmin",32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    single_op("s_maxmax",32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 64'h3FFF_FFFF_0000_0001);
    single_op("s_minmax",32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000);
    single_op("u_min2",  32'h8000_0000, 32'h0000_0002, 1'b0, 64'h0000_0001_0000_0000);
    single_op("s_m1x3",  32'hFFFF_FFFF, 32'h0000_0003, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
    single_op("u_m1x3",  32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 64'h0000_0002_FFFF_FFFD);
    single_op("s_zero",  32'h0000_0000, 32'h1234_5678, 1'b1, 64'h0000_0000_0000_0000);
    single_op("u_sq16",  32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000);

    // back-to-back stream, out_ready low in cycles 4..6
    st_a = '{32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0100};
    st_b = '{32'd3, 32'd5,         32'hFFFF_FFFF, 32'd2,         32'h0000_0100};
    st_s = '{1'b1,  1'b1,          1'b0,          1'b1,          1'b0};
    st_e = '{64'h6, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFE_0000_0001,
             64'h0000_0000_FFFF_FFFE, 64'h0000_0000_0001_0000};
    issued = 0; recv = 0; first_cyc = -1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 6);
      if (issued < 5) begin
        in_valid  = 1'b1;
        in_a      = st_a[issued];
        in_b      = st_b[issued];
        in_signed = st_s[issued];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      exp_rdy = !(cyc >= 4 && cyc <= 6);
      check($sformatf("strm_rdy_c%0d", cyc), 64'(in_ready), 64'(exp_rdy));
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (recv < 5) check($sformatf("strm_p%0d_c%0d", recv, cyc), out_p, st_e[recv]);
        else          check("strm_extra", 64'(out_valid), 64'd0);
        if (out_ready) recv++;
      end
      if (in_valid && in_ready) issued++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("strm_first_cyc", 64'(first_cyc), 64'd3);
    check("strm_count", 64'(recv), 64'd5);

    // flush with three ops in flight, third presented in the flush cycle
    in_valid = 1'b1; in_signed = 1'b0; in_a = 32'd2; in_b = 32'd3;
    tick;
    in_a = 32'd4; in_b = 32'd5;
    tick;
    in_a = 32'd6; in_b = 32'd7; flush = 1'b1;
    tick;
    in_valid = 1'b0; flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("flush_nv%0d", i), 64'(out_valid), 64'd0);
      check($sformatf("flush_hold%0d", i), out_p, st_e[4]);
      tick;
    end
    single_op("flush_next", 32'd5, 32'd7, 1'b0, 64'd35);

    // reset pulse mid-stream
    in_valid = 1'b1; in_signed = 1'b1; in_a = 32'd9; in_b = 32'd9;
    tick;
    in_a = 32'd10; in_b = 32'd10;
    tick;
    in_valid = 1'b0; reset = 1'b1;
    tick;
    reset = 1'b0;
    check("mrst_valid", 64'(out_valid), 64'd0);
    check("mrst_p", out_p, 64'd0);
    check("mrst_rdy", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick;
      check($sformatf("mrst_nv%0d", i), 64'(out_valid), 64'd0);
    end
    single_op("mrst_next", 32'hFFFF_FFFE, 32'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA);

`ifdef MUL_ACC_EN
    in_acc_en = 1'b1;
    in_acc = 64'h0000_0001_0000_0000; in_acc_sub = 1'b0;
    single_op("acc_add", 32'd2, 32'd3, 1'b0, 64'h0000_0001_0000_0006);
    in_acc = 64'h0; in_acc_sub = 1'b1;
    single_op("acc_sub", 32'd2, 32'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA);
    in_acc = 64'hFFFF_FFFF_FFFF_FFFF; in_acc_sub = 1'b0;
    single_op("acc_wrap", 32'd1, 32'd1, 1'b1, 64'h0000_0000_0000_0000);
    in_acc_en = 1'b0; in_acc_sub = 1'b0; in_acc = '0;
`endif

    // streamed sweep with random gaps and back-pressure
    n_sent = 0; n_recv = 0; accepted = 1'b0;
    for (int cyc = 0; cyc < 8000 && n_recv < N_RAND; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || accepted) begin
        if (n_sent < N_RAND && $urandom_range(0, 4) != 0) begin
          in_valid  = 1'b1;
          in_a      = pick();
          in_b      = pick();
          in_signed = 1'($urandom_range(0, 1));
        end else begin
          in_valid = 1'b0;
        end
      end
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("rnd_extra", 64'(out_valid), 64'd0);
        end else begin
          check($sformatf("rnd_%0d", n_recv), out_p, q.pop_front());
          n_recv++;
        end
      end
      accepted = in_valid && in_ready;
      if (accepted) begin
        q.push_back(ref_mul(in_a, in_b, in_signed));
        n_sent++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("rnd_count", 64'(n_recv), 64'(N_RAND));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
